// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: shared width, reference step and FSM state type for freq_step_tone_gen
package tone_gen_pkg;
  localparam int ACC_W = 32;
  localparam logic [31:0] STEP_1KHZ_50MHZ = 32'd85899;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/phase_accumulator.sv
// phase_accumulator: NCO phase register; wrap is the carry-out of acc + step
module phase_accumulator
  import tone_gen_pkg::*;
#(
  parameter int ACC_W = tone_gen_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [ACC_W-1:0] step,
  output logic [ACC_W-1:0] acc,
  output logic             wrap
);
  logic [ACC_W-1:0] sum;
  assign {wrap, sum} = {1'b0, acc} + {1'b0, step};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc <= '0;
    else acc <= clear ? '0 : sum;
endmodule

// File: rtl/freq_step_tone_gen.sv
// freq_step_tone_gen: NCO buzzer tone from a LUT freq_step, steps applied only at phase wrap.
// Optional TONE_DUTY_EN adds a duty[7:0] input for a programmable duty cycle.
module freq_step_tone_gen
  import tone_gen_pkg::*;
#(
  parameter int ACC_W  = tone_gen_pkg::ACC_W,
  parameter int STEP_W = ACC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [STEP_W-1:0] freq_step,
`ifdef TONE_DUTY_EN
  input  logic [7:0]        duty,
`endif
  output logic              tone_out,
  output logic              busy,
  output logic              step_loaded
);
  state_t state;
  logic [ACC_W-1:0] active_step;
  logic [ACC_W-1:0] phase_acc;
  logic wrap;
  logic start;
  logic stop;
  logic reload;
  logic clear;
  phase_accumulator #(.ACC_W(ACC_W)) u_acc (
    .clk(clk), .reset_n(reset_n), .clear(clear), .step(active_step), .acc(phase_acc), .wrap(wrap)
  );
  assign busy   = state != IDLE;
  assign start  = !busy && enable && freq_step != '0;
  // a finished period ends the tone when the request is gone or silenced
  assign stop   = busy && wrap && (!enable || freq_step == '0);
  assign reload = busy && wrap && enable && freq_step != '0 && freq_step != active_step;
  assign clear  = !busy || stop;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      active_step <= '0;
      step_loaded <= 1'b0;
    end else begin
      step_loaded <= start || reload;
      if (start || reload) active_step <= freq_step;
      state <= !busy ? (start ? RUN : IDLE) : stop ? IDLE : (wrap || enable) ? RUN : DRAIN;
    end
`ifdef TONE_DUTY_EN
  logic [7:0] duty_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) duty_q <= '0;
    else if (start || (busy && wrap)) duty_q <= duty;
  assign tone_out = busy && phase_acc[ACC_W-1 -: 8] < duty_q;
`else
  assign tone_out = phase_acc[ACC_W-1];
`endif
endmodule

// File: tb/tb_freq_step_tone_gen.sv
// tb_freq_step_tone_gen: scoreboard bench with a phase-arithmetic reference model
module tb_freq_step_tone_gen;
  import tone_gen_pkg::*;
  localparam longint FULL = 64'h1_0000_0000;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [31:0] freq_step = '0;
  logic tone_out;
  logic busy;
  logic step_loaded;
`ifdef TONE_DUTY_EN
  logic [7:0] duty = 8'd128;
`endif
  freq_step_tone_gen dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .freq_step(freq_step),
`ifdef TONE_DUTY_EN
    .duty(duty),
`endif
    .tone_out(tone_out),
    .busy(busy),
    .step_loaded(step_loaded)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] e_mon;
  longint m_phase = 0;
  longint m_step = 0;
  int m_mode = 0;
  bit m_loaded = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // mode: 0 silent, 1 sounding, 2 finishing the current period after enable dropped
  function automatic void model_step(input bit en, input longint fs);
    longint nxt;
    nxt = m_phase + m_step;
    m_loaded = 0;
    if (m_mode == 0) begin
      if (en && fs != 0) begin
        m_step = fs; m_phase = 0; m_loaded = 1; m_mode = 1;
      end
    end else if (nxt >= FULL) begin
      if (!en || fs == 0) begin
        m_mode = 0; m_phase = 0;
      end else begin
        m_phase = nxt - FULL; m_mode = 1;
        if (fs != m_step) begin m_step = fs; m_loaded = 1; end
      end
    end else begin
      m_phase = nxt;
      m_mode = en ? 1 : 2;
    end
  endfunction
  task automatic cycle(input bit en, input logic [31:0] fs);
    enable = en;
    freq_step = fs;
    @(posedge clk);
    model_step(en, longint'(fs));
    exp_q.push_back({m_phase >= FULL / 2, m_mode != 0, m_loaded});
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", {29'd0, tone_out, busy, step_loaded}, 32'd0);
    enable = 1'b0;
    freq_step = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_phase = 0; m_step = 0; m_mode = 0; m_loaded = 0;
  endtask
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("outputs_tone_busy_loaded", {29'd0, tone_out, busy, step_loaded}, {29'd0, e_mon});
    end
  initial begin
    int lat;
    logic [31:0] fs;
    #12;
    check("reset_state", {29'd0, tone_out, busy, step_loaded}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'd0);
    for (int i = 0; i < 14; i++) cycle(1'b1, 32'h4000_0000);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h8000_0000);
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'h4000_0000);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h2000_0000);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h2000_0000);
    fs = 32'h4000_0000;
    for (int s = 0; s < 200; s++) begin
      case ($urandom_range(0, 5))
        0: fs = 32'd0;
        1: fs = 32'h8000_0000;
        2: fs = 32'h4000_0000;
        3: fs = 32'h2000_0000;
        4: fs = $urandom | 32'h0400_0000;
        default: fs = fs;
      endcase
      lat = $urandom_range(1, 30);
      for (int i = 0; i < lat; i++) cycle($urandom_range(0, 9) != 0, fs);
    end
    do_reset();
    cycle(1'b1, STEP_1KHZ_50MHZ);
    check("1khz_step_loaded", {31'd0, step_loaded}, 32'd1);
    lat = 0;
    while (!tone_out && lat < 30000) begin
      cycle(1'b1, STEP_1KHZ_50MHZ);
      lat++;
    end
    check("1khz_first_rise_latency", lat,
          32'((FULL / 2 + longint'(STEP_1KHZ_50MHZ) - 1) / longint'(STEP_1KHZ_50MHZ)));
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h8000_0000);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/freq_step_tone_gen.md
Name: freq_step_tone_gen

Overview:
- Consumer end of the distance-to-frequency path: takes the 32-bit freq_step word produced by the distance-to-frequency LUT and synthesizes the buzzer tone.
- Built as a phase-accumulator NCO, so tone frequency = f_clk * active_step / 2^ACC_W.
- New steps are taken only at a phase wrap, so frequency changes and stops are glitch-free: no truncated high pulse ever reaches the buzzer.

Parameters:
- ACC_W, 32, phase accumulator width; equals freq_step width.
- STEP_W, 32, freq_step input width; must equal ACC_W.

Ports:
- clk  input  1  system clock (50 MHz on board).
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  tone request; same signal that enables the LUT.
- freq_step  input  STEP_W  phase increment from the LUT; 0 means silence.
- tone_out  output  1  square-wave buzzer drive.
- busy  output  1  high whenever state != IDLE.
- step_loaded  output  1  one-cycle pulse when freq_step is captured into active_step.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; phase_acc=0; active_step=0; tone_out=0; busy=0; step_loaded=0.
  - Reset dominates all other events, including mid-tone.
- Output relations:
  - tone_out is combinationally phase_acc[ACC_W-1]; phase_acc is a register.
  - busy is decoded from state.
- Accumulation: phase_acc <= phase_acc + active_step, modulo 2^ACC_W. Wrap = carry-out of that add.
- IDLE:
  - phase_acc held at 0.
  - If enable=1 and freq_step!=0 at a clock edge: active_step<=freq_step, phase_acc<=0, step_loaded=1 for that cycle, go to RUN.
  - Otherwise remain in IDLE.
- RUN (accumulate every cycle):
  - Wrap cycle, enable=1, freq_step!=0, freq_step!=active_step: active_step<=freq_step, step_loaded pulse. The new step applies from the next add.
  - Wrap cycle, enable=1, freq_step==active_step: no load, no pulse.
  - Wrap cycle, freq_step==0: phase_acc<=0, go to IDLE.
  - Non-wrap cycle: enable=0 -> DRAIN. freq_step changes are ignored.
- DRAIN (accumulate every cycle with the current active_step):
  - On wrap: phase_acc<=0, go to IDLE.
  - Non-wrap cycle with enable=1 again: return to RUN, no reload; the step is re-evaluated at the next wrap.
  - Wrap coinciding with enable=1: go to RUN and apply the RUN wrap rules.
- Latency:
  - step_loaded is asserted in cycle N+1 after enable/freq_step are seen at edge N.
  - First tone_out rise occurs ceil(2^(ACC_W-1)/active_step) cycles after step_loaded.
- Boundary: active_step=2^(ACC_W-1) gives tone_out toggling every cycle (f_clk/2 maximum). Steps above that alias, which is permitted and undetected.

Optional Feature:
- Macro: TONE_DUTY_EN.
- Defined:
  - Adds input port duty [7:0].
  - tone_out = (phase_acc[ACC_W-1 -: 8] < duty).
  - duty=0 gives constant 0; duty=128 gives 50%; duty=255 gives 255/256 high.
  - duty is sampled only on wrap cycles or IDLE->RUN, into a duty register reset to 0.
- Not defined: no duty port; tone_out = phase_acc MSB (50% duty).

Decomposition:
- tone_gen_pkg:
  - ACC_W constant.
  - state enum typedef {IDLE, RUN, DRAIN}.
  - STEP_1KHZ_50MHZ = 32'd85899, i.e. 999.99 Hz at 50 MHz.
- One sub-module, phase_accumulator:
  - Inputs: clk, reset_n, clear, step.
  - Outputs: acc, wrap.
  - The FSM sits in freq_step_tone_gen.

Test Plan:
1. Reset mid-RUN with step=2^30: assert reset_n=0 -> tone_out, busy, step_loaded drop to 0 immediately (asynchronously), before the next clk edge.
2. enable=1, freq_step=2^30 -> step_loaded pulse one cycle later; tone_out pattern 0,0,1,1 repeating (period 4 cycles); busy=1.
3. freq_step=2^31 then change to 2^30 mid-period -> switch occurs only at the next wrap; step_loaded pulses exactly once; no high pulse shorter than 1 cycle (2^31) or 2 cycles (2^30).
4. Step=2^29, drop enable 3 cycles after step_loaded -> DRAIN, tone completes the current 8-cycle period; IDLE on wrap with tone_out=0; busy falls the same cycle.
5. enable=1, freq_step=0 -> remains IDLE, no step_loaded, tone_out=0. RUN then freq_step=0 -> IDLE at the next wrap.
6. STEP_1KHZ_50MHZ for 200,000 cycles -> exactly 4 tone_out rising edges (1 kHz at 50 MHz). With TONE_DUTY_EN and duty=64 -> high time ≈25% (12,500 ±1 cycles per period).
